ucr_seq: RTL and testbench
==========================

Name: ucr_seq

Overview:
- Control sequencer that sits directly upstream of a cascaded chain of NDIG UCR4-style 4-bit up/down counter stages.
- Accepts a start request carrying a preset value and a direction. Drives the chain's D bus, the shared SEL code and the carry-in to the least-significant stage. Loads the chain, then steps it one count per enabled cycle until the chain reaches its terminal value.
- Reports completion and the number of steps taken. Serves as the shift-count / loop-count controller feeding the counter datapath.

Parameters:
- NDIG, 3, number of 4-bit counter stages in the chain; counter width W = 4*NDIG.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-low reset (0 = reset, sampled on posedge CLK).
- START  in  1  request pulse; accepted only in IDLE.
- UP  in  1  direction, sampled with START: 1 = count up to all-ones, 0 = count down to zero.
- PRESET  in  W  value to load, sampled with START; bit 0 = MSB.
- STEP_EN  in  1  stall control; 0 holds the chain in RUN with no step.
- ABORT  in  1  terminates RUN or LOAD; DONE pulses with ABORTED=1.
- CNT_Q  in  W  current chain value (concatenated stage Q, MS stage first).
- D  out  W  load data to chain stages.
- SEL  out  2  chain mode: 00 LOAD, 01 DEC, 10 INC, 11 HOLD.
- CIN  out  1  carry/borrow into least-significant stage.
- BUSY  out  1  high in LOAD and RUN.
- DONE  out  1  one-cycle completion pulse.
- ABORTED  out  1  valid with DONE; 1 if terminated by ABORT.
- STEPS  out  W  steps issued in the last or current operation; held after DONE until the next START.

Behaviour:
- Reset (RESET=0 at posedge): state IDLE; D=0, STEPS=0, DONE=0, ABORTED=0, latched direction=down. Outputs SEL=11 and CIN=0 while in IDLE. Reset mid-operation abandons it immediately with no DONE pulse.
- States and transitions:
  - IDLE→LOAD on START: latch PRESET into D and UP into the direction register; clear STEPS.
  - LOAD: one cycle; SEL=00, CIN=0; the chain captures D at the closing edge.
    - Next state RUN.
    - If ABORT=1, go to DONE with ABORTED=1 instead.
  - RUN: SEL=10 if up, else 01.
    - Terminal value T = all-ones if up, else 0.
    - CIN = STEP_EN & ~ABORT & (CNT_Q != T). This is combinational from current state and inputs.
    - STEPS increments by 1 on every edge where CIN=1. STEPS wraps modulo 2^W, which is unreachable in normal use.
    - If CNT_Q == T, go to DONE with ABORTED=0 and CIN=0.
    - If ABORT=1, go to DONE with ABORTED=1. ABORT has priority over terminal detection.
  - DONE: one cycle; DONE=1, SEL=11, CIN=0, BUSY=0; then IDLE. A START in the DONE cycle is ignored.
- Latency: START at edge n gives LOAD during cycle n+1, with the chain holding PRESET after edge n+2.
  - First step edge is n+3 when STEP_EN=1.
  - For a down-count from P with no stalls, DONE is high in cycle n+3+P. STEPS = P at that time.
- Preset already terminal (P=0 down, or all-ones up): RUN lasts one cycle, STEPS=0, ABORTED=0.
- START while BUSY or DONE: ignored. PRESET and UP are not re-sampled.
- STEP_EN=0 in RUN: SEL keeps the direction code and CIN=0, so the chain holds; no timeout.
- D is stable from LOAD until the next accepted START.
- No arithmetic on CNT_Q other than the equality compare with T. Wrap-around of the chain is prevented by stopping at T.

Test Plan:
- Bench drives an ideal W-bit counter model from SEL/CIN/D feeding CNT_Q, with NDIG=3.
- Reset: RESET=0 for 2 cycles with START=1 → SEL=11, CIN=0, BUSY=0, DONE=0, STEPS=0; no LOAD is issued.
- Down-count: START, UP=0, PRESET=12'h005, STEP_EN=1 → one SEL=00 cycle, then 5 cycles of SEL=01 with CIN=1. DONE pulses 8 cycles after the START edge with ABORTED=0, STEPS=5, CNT_Q=0.
- Up-count with stalls: UP=1, PRESET=12'hFFC, STEP_EN toggling 1,0,1,0,… → CIN=1 only when STEP_EN=1. DONE follows 3 steps, with STEPS=3 and CNT_Q=12'hFFF.
- Terminal preset: UP=0, PRESET=0 → LOAD, one RUN cycle with CIN=0, DONE with STEPS=0. Repeat with UP=1, PRESET=12'hFFF → same result.
- Abort: UP=0, PRESET=12'h100, ABORT=1 in the 4th RUN cycle → CIN=0 that cycle, DONE and ABORTED=1, STEPS=3, CNT_Q=12'h0FD. A START during BUSY is ignored.
- Reset mid-RUN: RESET=0 during RUN of PRESET=12'h010 → next cycle IDLE, SEL=11, STEPS=0, no DONE pulse. A following START runs normally.

Source files
------------

// File: rtl/ucr_seq.sv
// rtl/ucr_seq.sv - load/step/terminate sequencer for a cascaded UCR4 counter chain
module ucr_seq #(
   parameter int NDIG = 3,
   localparam int W = 4 * NDIG
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         START,
   input  logic         UP,
   input  logic [0:W-1] PRESET,
   input  logic         STEP_EN,
   input  logic         ABORT,
   input  logic [0:W-1] CNT_Q,
   output logic [0:W-1] D,
   output logic [1:0]   SEL,
   output logic         CIN,
   output logic         BUSY,
   output logic         DONE,
   output logic         ABORTED,
   output logic [W-1:0] STEPS
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] SEL_LOAD = 2'b00;
   localparam logic [1:0] SEL_DEC  = 2'b01;
   localparam logic [1:0] SEL_INC  = 2'b10;
   localparam logic [1:0] SEL_HOLD = 2'b11;

   logic [1:0]   state_q, state_d;
   logic [0:W-1] d_q, d_d;
   logic         up_q, up_d;
   logic [W-1:0] steps_q, steps_d;
   logic         aborted_q, aborted_d;

   logic         at_term;
   logic         step;

   // Terminal detect and step qualification; the only use of CNT_Q is equality with T
   always_comb begin
      at_term = up_q ? (&CNT_Q) : (CNT_Q == '0);
      step    = (state_q == S_RUN) & STEP_EN & ~ABORT & ~at_term;
   end

   // Next-state logic: START latches the operation, ABORT outranks terminal detection
   always_comb begin
      state_d   = state_q;
      d_d       = d_q;
      up_d      = up_q;
      steps_d   = steps_q;
      aborted_d = aborted_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d   = S_LOAD;
               d_d       = PRESET;
               up_d      = UP;
               steps_d   = '0;
               aborted_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (ABORT) begin
               state_d   = S_DONE;
               aborted_d = 1'b1;
            end else begin
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (step) begin
               steps_d = steps_q + W'(1);
            end
            if (ABORT) begin
               state_d   = S_DONE;
               aborted_d = 1'b1;
            end else if (at_term) begin
               state_d   = S_DONE;
               aborted_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q   <= S_IDLE;
         d_q       <= '0;
         up_q      <= 1'b0;
         steps_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         d_q       <= d_d;
         up_q      <= up_d;
         steps_q   <= steps_d;
         aborted_q <= aborted_d;
      end
   end

   // Chain control outputs decoded from the current state
   always_comb begin
      case (state_q)
         S_LOAD:  SEL = SEL_LOAD;
         S_RUN:   SEL = up_q ? SEL_INC : SEL_DEC;
         default: SEL = SEL_HOLD;
      endcase
      D       = d_q;
      CIN     = step;
      BUSY    = (state_q == S_LOAD) | (state_q == S_RUN);
      DONE    = (state_q == S_DONE);
      ABORTED = (state_q == S_DONE) & aborted_q;
      STEPS   = steps_q;
   end

endmodule

// File: tb/tb_ucr_seq.sv
// tb/tb_ucr_seq.sv - randomized self-checking bench for ucr_seq with an ideal counter chain
module tb_ucr_seq;

   localparam int NDIG = 3;
   localparam int W = 4 * NDIG;
   localparam logic [W-1:0] ONES = {W{1'b1}};

   logic         clk;
   logic         reset;
   logic         start;
   logic         up_i;
   logic [0:W-1] preset;
   logic         step_en;
   logic         abort;
   logic [0:W-1] cnt_q;
   logic [0:W-1] d;
   logic [1:0]   sel;
   logic         cin;
   logic         busy;
   logic         done;
   logic         aborted;
   logic [W-1:0] steps;

   int passed = 0;
   int total  = 0;

   logic         exp_valid = 1'b0;
   logic [1:0]   e_sel;
   logic         e_cin, e_busy, e_done, e_ab, e_cnt_valid;
   logic [W-1:0] e_steps, e_cnt, e_d;

   logic [W-1:0] md = '0;
   logic [W-1:0] last_steps = '0;
   int           m_cycles;
   logic [W-1:0] m_steps;
   logic [W-1:0] m_v;

   ucr_seq #(.NDIG(NDIG)) dut (
      .CLK(clk), .RESET(reset), .START(start), .UP(up_i), .PRESET(preset),
      .STEP_EN(step_en), .ABORT(abort), .CNT_Q(cnt_q), .D(d), .SEL(sel),
      .CIN(cin), .BUSY(busy), .DONE(done), .ABORTED(aborted), .STEPS(steps)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ideal W-bit counter chain driven by the sequencer
   initial cnt_q = '0;
   always @(posedge clk) begin
      if (sel == 2'b00) cnt_q <= d;
      else if (cin && sel == 2'b10) cnt_q <= cnt_q + W'(1);
      else if (cin && sel == 2'b01) cnt_q <= cnt_q - W'(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
   endtask

   // Per-cycle compare against the expectation set for this cycle
   always @(negedge clk) begin
      if (exp_valid) begin
         check("sel", 32'(sel), 32'(e_sel));
         check("cin", 32'(cin), 32'(e_cin));
         check("busy", 32'(busy), 32'(e_busy));
         check("done", 32'(done), 32'(e_done));
         if (e_done) check("aborted", 32'(aborted), 32'(e_ab));
         check("steps", 32'(steps), 32'(e_steps));
         check("d", 32'(d), 32'(e_d));
         if (e_cnt_valid) check("cnt_q", 32'(cnt_q), 32'(e_cnt));
      end
   end

   task automatic cyc(input logic rst, input logic st, input logic [W-1:0] pre, input logic u,
                      input logic en, input logic ab, input logic [1:0] es, input logic ec,
                      input logic eb, input logic edn, input logic eab, input logic [W-1:0] est,
                      input logic ecv, input logic [W-1:0] ecnt);
      @(posedge clk);
      #1;
      reset = rst; start = st; preset = pre; up_i = u; step_en = en; abort = ab;
      e_sel = es; e_cin = ec; e_busy = eb; e_done = edn; e_ab = eab;
      e_steps = est; e_cnt_valid = ecv; e_cnt = ecnt; e_d = md;
      exp_valid = 1'b1;
   endtask

   task automatic idle_cyc(input logic st, input logic [W-1:0] pre, input logic u);
      cyc(1'b1, st, pre, u, 1'($urandom), 1'($urandom), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0,
          last_steps, 1'b0, '0);
   endtask

   // One operation from the START request to DONE (or to a mid-run reset).
   // mode: 0 = STEP_EN always 1, 1 = toggling 1,0,1,..., 2 = random.
   task automatic run_op(input logic [W-1:0] p, input logic u, input int mode,
                         input int abort_k, input int rst_k);
      logic [W-1:0] v, s, t;
      logic [1:0]   dir;
      logic         en, ab, term, c, rst;
      int           k;
      t   = u ? ONES : '0;
      dir = u ? 2'b10 : 2'b01;
      idle_cyc(1'b1, p, u);
      md = p;
      ab = (abort_k == 0);
      cyc(1'b1, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ab,
          2'b00, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      v = p; s = '0; k = 1; m_cycles = 1;
      if (!ab) begin
         while (1) begin
            if (mode == 0) en = 1'b1;
            else if (mode == 1) en = k[0];
            else en = ($urandom % 4) != 0;
            ab   = (k == abort_k);
            term = (v == t);
            c    = en & ~ab & ~term;
            rst  = (k == rst_k);
            cyc(~rst, 1'($urandom), W'($urandom), 1'($urandom), en, ab,
                dir, c, 1'b1, 1'b0, 1'b0, s, 1'b1, v);
            m_cycles++;
            if (rst) begin
               md = '0;
               last_steps = '0;
               m_steps = s;
               m_v = v;
               return;
            end
            if (c) begin
               v = u ? v + W'(1) : v - W'(1);
               s = s + W'(1);
            end
            k++;
            if (ab || term) break;
            if (k > 6000) begin
               check("model_bound", 32'(k), 32'(0));
               break;
            end
         end
      end
      cyc(1'b1, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          2'b11, 1'b0, 1'b0, 1'b1, ab, s, 1'b1, v);
      m_cycles++;
      last_steps = s;
      m_steps = s;
      m_v = v;
   endtask

   initial begin
      logic         u;
      logic [W-1:0] p;
      int           ak;
      reset = 1'b0; start = 1'b1; up_i = 1'b1; preset = 12'h123; step_en = 1'b1; abort = 1'b0;
      @(posedge clk);
      // Reset held with START=1 for two cycles: no LOAD may be issued
      cyc(1'b0, 1'b1, 12'h456, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      cyc(1'b0, 1'b1, 12'h789, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      idle_cyc(1'b0, '0, 1'b0);
      idle_cyc(1'b0, '0, 1'b0);

      run_op(12'h005, 1'b0, 0, -1, -1);
      check("pin_down_cycles", 32'(m_cycles), 32'd8);
      check("pin_down_steps", 32'(m_steps), 32'd5);
      check("pin_down_cnt", 32'(m_v), 32'h000);
      idle_cyc(1'b0, '0, 1'b0);

      run_op(12'hFFC, 1'b1, 1, -1, -1);
      check("pin_up_steps", 32'(m_steps), 32'd3);
      check("pin_up_cnt", 32'(m_v), 32'hFFF);

      run_op(12'h000, 1'b0, 0, -1, -1);
      check("pin_term0_cycles", 32'(m_cycles), 32'd3);
      check("pin_term0_steps", 32'(m_steps), 32'd0);
      run_op(12'hFFF, 1'b1, 0, -1, -1);
      check("pin_termF_cycles", 32'(m_cycles), 32'd3);
      check("pin_termF_steps", 32'(m_steps), 32'd0);

      run_op(12'h100, 1'b0, 0, 4, -1);
      check("pin_abort_steps", 32'(m_steps), 32'd3);
      check("pin_abort_cnt", 32'(m_v), 32'h0FD);

      run_op(12'h020, 1'b1, 0, 0, -1);
      check("pin_loadabort_steps", 32'(m_steps), 32'd0);

      run_op(12'h010, 1'b0, 0, -1, 4);
      check("pin_rst_steps", 32'(m_steps), 32'd3);
      idle_cyc(1'b0, '0, 1'b0);
      run_op(12'h007, 1'b0, 2, -1, -1);
      check("pin_after_rst_cnt", 32'(m_v), 32'h000);

      for (int i = 0; i < 30; i++) begin
         u  = 1'($urandom);
         p  = W'($urandom_range(0, 30));
         if (u) p = ONES - p;
         ak = (($urandom % 4) == 0) ? int'($urandom_range(0, 12)) : -1;
         if (i == 10) begin
            p  = W'($urandom);
            ak = 40;
         end
         run_op(p, u, int'($urandom_range(0, 2)), ak, -1);
         if (($urandom % 2) == 0) idle_cyc(1'b0, '0, 1'b0);
      end

      idle_cyc(1'b0, '0, 1'b0);
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
